// File: rtl/pipe_front_ctrl.sv
// pipe_front_ctrl: fetch-side pipeline front end. Owns the PC, IF/ID and
// ID/EX registers and applies load-use stalls, EX bubbles and EX-stage
// branch redirects to them. Feeds decoded register fields back to the
// hazard detector and keeps saturating stall/redirect counters.
//
// Control semantics (sampled at each rising edge, strict priority):
//   rst > redirect_valid > stall_if/stall_id/flush_ex > normal advance.
//   stall_if | stall_id holds the PC; stall_id holds IF/ID; flush_ex
//   replaces whatever would enter ID/EX with a bubble. A redirect clears
//   both pipeline registers and ignores every stall/flush request.
module pipe_front_ctrl #(
   parameter int              PC_W     = 8,
   parameter int              INSTR_W  = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter logic [3:0]      LOAD_OP  = 4'h4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall_if,
   input  logic               stall_id,
   input  logic               flush_ex,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_pc,
   input  logic [INSTR_W-1:0] imem_instr,
   output logic [PC_W-1:0]    pc_out,
   output logic               ifid_valid,
   output logic [INSTR_W-1:0] ifid_instr,
   output logic [PC_W-1:0]    ifid_pc,
   output logic [1:0]         id_ra,
   output logic [1:0]         id_rb,
   output logic               idex_valid,
   output logic [INSTR_W-1:0] idex_instr,
   output logic [PC_W-1:0]    idex_pc,
   output logic [1:0]         ex_dest_reg,
   output logic               ex_mem_read,
   output logic [15:0]        stall_cnt,
   output logic [15:0]        flush_cnt
);

   // A stalled ID stage must also freeze fetch, otherwise the instruction
   // fetched this cycle would be lost.
   logic pc_hold;
   assign pc_hold = stall_if | stall_id;

   // PC: reset, redirect, hold, or increment (wraps naturally at 2^PC_W).
   always_ff @(posedge clk) begin
      if (rst)
         pc_out <= RESET_PC;
      else if (redirect_valid)
         pc_out <= redirect_pc;
      else if (!pc_hold)
         pc_out <= pc_out + PC_W'(1);
   end

   // IF/ID: cleared by a redirect, frozen by stall_id, else captures fetch.
   always_ff @(posedge clk) begin
      if (rst || redirect_valid) begin
         ifid_valid <= 1'b0;
         ifid_instr <= '0;
         ifid_pc    <= '0;
      end else if (!stall_id) begin
         ifid_valid <= 1'b1;
         ifid_instr <= imem_instr;
         ifid_pc    <= pc_out;
      end
   end

   // ID/EX: bubble on redirect or flush_ex, else takes IF/ID. Flushing
   // while ID is stalled keeps the held instruction from being duplicated.
   always_ff @(posedge clk) begin
      if (rst || redirect_valid || flush_ex) begin
         idex_valid <= 1'b0;
         idex_instr <= '0;
         idex_pc    <= '0;
      end else begin
         idex_valid <= ifid_valid;
         idex_instr <= ifid_instr;
         idex_pc    <= ifid_pc;
      end
   end

   // Saturating counters: PC-hold cycles (redirect cycles excluded) and redirects.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else if (redirect_valid) begin
         if (flush_cnt != 16'hFFFF)
            flush_cnt <= flush_cnt + 16'd1;
      end else if (pc_hold) begin
         if (stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

   // Decoded fields handed back to the hazard detector.
   always_comb begin
      id_ra       = ifid_instr[3:2];
      id_rb       = ifid_instr[1:0];
      ex_dest_reg = idex_instr[5:4];
      ex_mem_read = idex_valid & (idex_instr[15:12] == LOAD_OP);
   end

endmodule

// File: tb/tb_pipe_front_ctrl.sv
// Directed bench for pipe_front_ctrl: reset/free-run, load-use stall,
// redirect during stall, PC wrap, stall counter saturation, reset mid-stall.
module tb_pipe_front_ctrl;

   localparam int PC_W    = 8;
   localparam int INSTR_W = 16;

   logic               clk;
   logic               rst;
   logic               stall_if;
   logic               stall_id;
   logic               flush_ex;
   logic               redirect_valid;
   logic [PC_W-1:0]    redirect_pc;
   logic [INSTR_W-1:0] imem_instr;
   logic [PC_W-1:0]    pc_out;
   logic               ifid_valid;
   logic [INSTR_W-1:0] ifid_instr;
   logic [PC_W-1:0]    ifid_pc;
   logic [1:0]         id_ra;
   logic [1:0]         id_rb;
   logic               idex_valid;
   logic [INSTR_W-1:0] idex_instr;
   logic [PC_W-1:0]    idex_pc;
   logic [1:0]         ex_dest_reg;
   logic               ex_mem_read;
   logic [15:0]        stall_cnt;
   logic [15:0]        flush_cnt;

   int checks;
   int failures;
   logic [PC_W-1:0] exp_q[$];
   logic [INSTR_W-1:0] imem [0:255];

   pipe_front_ctrl #(
      .PC_W(PC_W), .INSTR_W(INSTR_W), .RESET_PC(8'h00), .LOAD_OP(4'h4)
   ) dut (
      .clk(clk), .rst(rst), .stall_if(stall_if), .stall_id(stall_id),
      .flush_ex(flush_ex), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .imem_instr(imem_instr), .pc_out(pc_out),
      .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
      .id_ra(id_ra), .id_rb(id_rb), .idex_valid(idex_valid),
      .idex_instr(idex_instr), .idex_pc(idex_pc), .ex_dest_reg(ex_dest_reg),
      .ex_mem_read(ex_mem_read), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   // combinational instruction memory
   assign imem_instr = imem[pc_out];

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // advance one cycle; outputs are sampled 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic si, input logic sd, input logic fe,
                        input logic rv, input logic [PC_W-1:0] rp);
      stall_if       = si;
      stall_id       = sd;
      flush_ex       = fe;
      redirect_valid = rv;
      redirect_pc    = rp;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_pc"},         32'(pc_out),      32'h0);
      chk({tag, "_ifid_valid"}, 32'(ifid_valid),  32'h0);
      chk({tag, "_ifid_instr"}, 32'(ifid_instr),  32'h0);
      chk({tag, "_ifid_pc"},    32'(ifid_pc),     32'h0);
      chk({tag, "_idex_valid"}, 32'(idex_valid),  32'h0);
      chk({tag, "_idex_instr"}, 32'(idex_instr),  32'h0);
      chk({tag, "_idex_pc"},    32'(idex_pc),     32'h0);
      chk({tag, "_mem_read"},   32'(ex_mem_read), 32'h0);
      chk({tag, "_stall_cnt"},  32'(stall_cnt),   32'h0);
      chk({tag, "_flush_cnt"},  32'(flush_cnt),   32'h0);
   endtask

   initial begin
      logic pc_moved;
      checks   = 0;
      failures = 0;
      for (int i = 0; i < 256; i++) imem[i] = 16'h1000 + 16'(i);
      rst = 1'b1;
      drive(0, 0, 0, 0, 8'h00);

      // 1. reset then free run
      step();
      step();
      chk_reset_state("reset");
      rst = 1'b0;
      exp_q.push_back(8'h01);
      exp_q.push_back(8'h02);
      exp_q.push_back(8'h03);
      step();
      chk("t1_pc1", 32'(pc_out), 32'(exp_q.pop_front()));
      chk("t1_ifid_instr", 32'(ifid_instr), 32'h1000);
      chk("t1_ifid_valid", 32'(ifid_valid), 32'h1);
      chk("t1_idex_valid0", 32'(idex_valid), 32'h0);
      step();
      chk("t1_pc2", 32'(pc_out), 32'(exp_q.pop_front()));
      chk("t1_idex_instr", 32'(idex_instr), 32'h1000);
      chk("t1_idex_valid", 32'(idex_valid), 32'h1);
      chk("t1_idex_pc", 32'(idex_pc), 32'h0);
      chk("t1_ifid_instr2", 32'(ifid_instr), 32'h1001);
      step();
      chk("t1_pc3", 32'(pc_out), 32'(exp_q.pop_front()));

      // 2. load-use: load at pc 3, dependent at pc 4
      imem[3] = 16'h4010;
      imem[4] = 16'h2004;
      step();
      step();
      chk("t2_pre_pc", 32'(pc_out), 32'h05);
      chk("t2_pre_mem_read", 32'(ex_mem_read), 32'h1);
      chk("t2_pre_dest", 32'(ex_dest_reg), 32'h1);
      chk("t2_pre_ra", 32'(id_ra), 32'h1);
      chk("t2_pre_rb", 32'(id_rb), 32'h0);
      chk("t2_pre_ifid", 32'(ifid_instr), 32'h2004);
      drive(1, 1, 1, 0, 8'h00);
      step();
      drive(0, 0, 0, 0, 8'h00);
      chk("t2_hold_pc", 32'(pc_out), 32'h05);
      chk("t2_hold_ifid", 32'(ifid_instr), 32'h2004);
      chk("t2_hold_ifid_pc", 32'(ifid_pc), 32'h04);
      chk("t2_bubble_valid", 32'(idex_valid), 32'h0);
      chk("t2_bubble_instr", 32'(idex_instr), 32'h0);
      chk("t2_bubble_mem_read", 32'(ex_mem_read), 32'h0);
      chk("t2_bubble_dest", 32'(ex_dest_reg), 32'h0);
      chk("t2_stall_cnt", 32'(stall_cnt), 32'h1);
      step();
      chk("t2_post_pc", 32'(pc_out), 32'h06);
      chk("t2_post_idex", 32'(idex_instr), 32'h2004);
      chk("t2_post_idex_valid", 32'(idex_valid), 32'h1);
      chk("t2_post_idex_pc", 32'(idex_pc), 32'h04);
      chk("t2_post_ifid", 32'(ifid_instr), 32'h1005);
      chk("t2_post_stall_cnt", 32'(stall_cnt), 32'h1);

      // 3. redirect wins over simultaneous stall/flush
      drive(1, 1, 1, 1, 8'h40);
      step();
      drive(0, 0, 0, 0, 8'h00);
      chk("t3_pc", 32'(pc_out), 32'h40);
      chk("t3_ifid_valid", 32'(ifid_valid), 32'h0);
      chk("t3_ifid_instr", 32'(ifid_instr), 32'h0);
      chk("t3_idex_valid", 32'(idex_valid), 32'h0);
      chk("t3_flush_cnt", 32'(flush_cnt), 32'h1);
      chk("t3_stall_cnt", 32'(stall_cnt), 32'h1);
      step();
      chk("t3_next_pc", 32'(pc_out), 32'h41);
      chk("t3_next_ifid", 32'(ifid_instr), 32'h1040);
      chk("t3_next_idex_valid", 32'(idex_valid), 32'h0);

      // 4. PC wrap
      drive(0, 0, 0, 1, 8'hFF);
      step();
      drive(0, 0, 0, 0, 8'h00);
      chk("t4_pc_ff", 32'(pc_out), 32'hFF);
      chk("t4_flush_cnt", 32'(flush_cnt), 32'h2);
      step();
      chk("t4_pc_00", 32'(pc_out), 32'h00);
      chk("t4_ifid_pc", 32'(ifid_pc), 32'hFF);
      chk("t4_ifid_instr", 32'(ifid_instr), 32'h10FF);
      step();
      chk("t4_pc_01", 32'(pc_out), 32'h01);

      // 5. stall counter saturation (counter starts at 1)
      pc_moved = 1'b0;
      drive(1, 0, 0, 0, 8'h00);
      for (int k = 1; k <= 65540; k++) begin
         step();
         if (pc_out !== 8'h01) pc_moved = 1'b1;
         if (k == 65533) chk("t5_cnt_fffe", 32'(stall_cnt), 32'hFFFE);
         if (k == 65534) chk("t5_cnt_ffff", 32'(stall_cnt), 32'hFFFF);
      end
      chk("t5_cnt_sat", 32'(stall_cnt), 32'hFFFF);
      chk("t5_pc_const", 32'(pc_moved), 32'h0);
      chk("t5_flush_cnt", 32'(flush_cnt), 32'h2);

      // 6. reset during stall and redirect
      rst = 1'b1;
      drive(1, 1, 1, 1, 8'h80);
      step();
      chk_reset_state("t6");
      rst = 1'b0;
      drive(0, 0, 0, 0, 8'h00);
      step();
      chk("t6_after_pc", 32'(pc_out), 32'h01);
      chk("t6_after_ifid", 32'(ifid_instr), 32'h1000);
      chk("t6_after_flush_cnt", 32'(flush_cnt), 32'h0);
      chk("t6_after_stall_cnt", 32'(stall_cnt), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
